// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - four-source round-robin interrupt controller with bus-mapped MASK/PENDING/CAUSE
module irq_controller #(
  parameter logic [7:0] BASE_ADDR = 8'hE0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] BUS_ADDR,
  inout  wire  [7:0] BUS_DATA,
  input  logic       BUS_WE,
  input  logic [3:0] IRQ_IN,
  output logic [3:0] IRQ_ACK_OUT,
  output logic       CPU_INT_RAISE,
  input  logic       CPU_INT_ACK
);

  localparam logic [7:0] ADDR_MASK    = BASE_ADDR;
  localparam logic [7:0] ADDR_PENDING = BASE_ADDR + 8'd1;
  localparam logic [7:0] ADDR_CAUSE   = BASE_ADDR + 8'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RAISE = 2'd1,
    ST_ACKED = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] mask_q, mask_d;
  logic [3:0] pending_q, pending_d;
  logic [3:0] irq_in_q, irq_in_d;
  logic       cause_valid_q, cause_valid_d;
  logic [1:0] cause_id_q, cause_id_d;
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic       raise_q, raise_d;
  logic [3:0] ack_out_q, ack_out_d;
  logic       rd_en_q, rd_en_d;
  logic [7:0] rd_data_q, rd_data_d;

  logic [3:0] irq_rise;
  logic [3:0] eligible;
  logic       sel_found;
  logic [1:0] sel_id;
  logic       ack_accept;
  logic [3:0] ack_onehot;
  logic [3:0] clr_mask;
  logic       unused_bus_hi;

  // Only the low nibble of a MASK write is stored; upper data bits are don't-care
  assign unused_bus_hi = ^BUS_DATA[7:4];

  // Rising-edge detect against the registered copy of each request line
  assign irq_rise   = IRQ_IN & ~irq_in_q;
  assign eligible   = pending_q & mask_q;
  assign ack_accept = (state_q == ST_RAISE) && CPU_INT_ACK;
  assign ack_onehot = 4'b0001 << cause_id_q;
  assign clr_mask   = ack_accept ? ack_onehot : 4'b0000;

  // Round-robin pick: first eligible source at or after rr_ptr, wrapping 3->0
  always_comb begin
    logic [1:0] cand;
    sel_found = 1'b0;
    sel_id    = rr_ptr_q;
    cand      = rr_ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = rr_ptr_q + 2'(k);
      if (!sel_found && eligible[cand]) begin
        sel_found = 1'b1;
        sel_id    = cand;
      end
    end
  end

  // Pending, edge-detect and MASK next-state; a new edge beats the ack clear
  always_comb begin
    irq_in_d  = IRQ_IN;
    pending_d = (pending_q & ~clr_mask) | irq_rise;
    mask_d    = mask_q;
    if (BUS_WE && (BUS_ADDR == ADDR_MASK)) begin
      mask_d = BUS_DATA[3:0];
    end
  end

  // Raise/ack FSM next-state; outputs are registered alongside the state
  always_comb begin
    state_d       = state_q;
    cause_valid_d = cause_valid_q;
    cause_id_d    = cause_id_q;
    rr_ptr_d      = rr_ptr_q;
    raise_d       = raise_q;
    ack_out_d     = 4'b0000;
    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          cause_id_d    = sel_id;
          cause_valid_d = 1'b1;
          raise_d       = 1'b1;
          state_d       = ST_RAISE;
        end
      end
      ST_RAISE: begin
        if (CPU_INT_ACK) begin
          ack_out_d = ack_onehot;
          rr_ptr_d  = cause_id_q + 2'd1;
          raise_d   = 1'b0;
          state_d   = ST_ACKED;
        end
      end
      ST_ACKED: begin
        cause_valid_d = 1'b0;
        state_d       = ST_IDLE;
      end
      default: begin
        raise_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered read: capture the addressed register, drive it the following cycle
  always_comb begin
    rd_en_d   = 1'b0;
    rd_data_d = 8'h00;
    if (!BUS_WE) begin
      if (BUS_ADDR == ADDR_MASK) begin
        rd_en_d   = 1'b1;
        rd_data_d = {4'b0000, mask_q};
      end else if (BUS_ADDR == ADDR_PENDING) begin
        rd_en_d   = 1'b1;
        rd_data_d = {4'b0000, pending_q};
      end else if (BUS_ADDR == ADDR_CAUSE) begin
        rd_en_d   = 1'b1;
        rd_data_d = {cause_valid_q, 5'b00000, cause_id_q};
      end
    end
  end

  // All state flops; async reset drops raise and ack pulses immediately
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= ST_IDLE;
      mask_q        <= 4'b0000;
      pending_q     <= 4'b0000;
      irq_in_q      <= 4'b0000;
      cause_valid_q <= 1'b0;
      cause_id_q    <= 2'd0;
      rr_ptr_q      <= 2'd0;
      raise_q       <= 1'b0;
      ack_out_q     <= 4'b0000;
      rd_en_q       <= 1'b0;
      rd_data_q     <= 8'h00;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      pending_q     <= pending_d;
      irq_in_q      <= irq_in_d;
      cause_valid_q <= cause_valid_d;
      cause_id_q    <= cause_id_d;
      rr_ptr_q      <= rr_ptr_d;
      raise_q       <= raise_d;
      ack_out_q     <= ack_out_d;
      rd_en_q       <= rd_en_d;
      rd_data_q     <= rd_data_d;
    end
  end

  assign IRQ_ACK_OUT   = ack_out_q;
  assign CPU_INT_RAISE = raise_q;
  assign BUS_DATA      = rd_en_q ? rd_data_q : 8'hzz;

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - directed vector bench for irq_controller
module tb_irq_controller;

  logic       clk;
  logic       rst_n;
  logic [7:0] bus_addr;
  logic       bus_we;
  logic [3:0] irq_in;
  logic [3:0] irq_ack_out;
  logic       cpu_int_raise;
  logic       cpu_ack;
  logic       tb_drv;
  logic [7:0] tb_wdata;
  tri1  [7:0] bus_data;

  int checks = 0;
  int errors = 0;

  // Undriven bus floats high through the pull, so 8'hFF stands for high-Z
  localparam logic [7:0] Z = 8'hFF;

  assign bus_data = tb_drv ? tb_wdata : 8'hzz;

  irq_controller #(.BASE_ADDR(8'hE0)) dut (
    .CLK          (clk),
    .RESET        (rst_n),
    .BUS_ADDR     (bus_addr),
    .BUS_DATA     (bus_data),
    .BUS_WE       (bus_we),
    .IRQ_IN       (irq_in),
    .IRQ_ACK_OUT  (irq_ack_out),
    .CPU_INT_RAISE(cpu_int_raise),
    .CPU_INT_ACK  (cpu_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [3:0] irq;
    logic       ack;
    logic       exp_raise;
    logic [3:0] exp_ack;
    logic [7:0] exp_bus;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic we, logic [7:0] a, logic [7:0] wd, logic [3:0] irq,
                              logic ack, logic er, logic [3:0] ea, logic [7:0] eb);
    vec_t v;
    v.rst_n = r; v.we = we; v.addr = a; v.wdata = wd; v.irq = irq; v.ack = ack;
    v.exp_raise = er; v.exp_ack = ea; v.exp_bus = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs; outputs are sampled 2 time units after the edge
  task automatic cyc(input logic we, input logic [7:0] addr, input logic [7:0] wd,
                     input logic [3:0] irq, input logic ack);
    bus_we   = we;
    bus_addr = addr;
    tb_wdata = wd;
    tb_drv   = we;
    irq_in   = irq;
    cpu_ack  = ack;
    @(posedge clk);
    #1;
    tb_drv = 1'b0;
    #1;
    chk("ack_onehot0", {7'd0, $onehot0(irq_ack_out)}, 8'd1);
  endtask

  initial begin
    rst_n = 1'b0; bus_addr = 8'h00; bus_we = 1'b0; irq_in = 4'h0;
    cpu_ack = 1'b0; tb_drv = 1'b0; tb_wdata = 8'h00;

    // basic raise/ack on source 2, register reads, ignored writes
    tbl.push_back(mk(0,0,8'h00,8'h00,4'h0,0, 0,4'h0,Z));
    tbl.push_back(mk(1,1,8'hE0,8'h0F,4'h0,0, 0,4'h0,Z));
    tbl.push_back(mk(1,0,8'hE0,8'h00,4'h4,0, 0,4'h0,8'h0F));
    tbl.push_back(mk(1,0,8'hE1,8'h00,4'h4,0, 1,4'h0,8'h04));
    tbl.push_back(mk(1,0,8'hE2,8'h00,4'h4,0, 1,4'h0,8'h82));
    tbl.push_back(mk(1,0,8'h00,8'h00,4'h4,1, 0,4'h4,Z));
    tbl.push_back(mk(1,0,8'hE1,8'h00,4'h0,0, 0,4'h0,8'h00));
    tbl.push_back(mk(1,0,8'h00,8'h00,4'h0,0, 0,4'h0,Z));
    tbl.push_back(mk(1,1,8'hE1,8'hFF,4'h0,0, 0,4'h0,Z));
    tbl.push_back(mk(1,1,8'hE2,8'hFF,4'h0,0, 0,4'h0,Z));
    tbl.push_back(mk(1,0,8'hE1,8'h00,4'h0,0, 0,4'h0,8'h00));
    tbl.push_back(mk(1,0,8'hE0,8'h00,4'h0,0, 0,4'h0,8'h0F));
    // round robin: 0 and 3 together, then 0 and 1 together
    tbl.push_back(mk(0,0,8'h00,8'h00,4'h0,0, 0,4'h0,Z));
    tbl.push_back(mk(1,1,8'hE0,8'h0F,4'h0,0, 0,4'h0,Z));
    tbl.push_back(mk(1,0,8'h00,8'h00,4'h9,0, 0,4'h0,Z));
    tbl.push_back(mk(1,0,8'h00,8'h00,4'h9,0, 1,4'h0,Z));
    tbl.push_back(mk(1,0,8'hE2,8'h00,4'h9,0, 1,4'h0,8'h80));
    tbl.push_back(mk(1,0,8'h00,8'h00,4'h9,1, 0,4'h1,Z));
    tbl.push_back(mk(1,0,8'h00,8'h00,4'h8,0, 0,4'h0,Z));
    tbl.push_back(mk(1,0,8'h00,8'h00,4'h8,0, 1,4'h0,Z));
    tbl.push_back(mk(1,0,8'hE2,8'h00,4'h8,0, 1,4'h0,8'h83));
    tbl.push_back(mk(1,0,8'h00,8'h00,4'h8,1, 0,4'h8,Z));
    tbl.push_back(mk(1,0,8'h00,8'h00,4'h0,0, 0,4'h0,Z));
    tbl.push_back(mk(1,0,8'h00,8'h00,4'h3,0, 0,4'h0,Z));
    tbl.push_back(mk(1,0,8'h00,8'h00,4'h3,0, 1,4'h0,Z));
    tbl.push_back(mk(1,0,8'hE2,8'h00,4'h3,0, 1,4'h0,8'h80));
    tbl.push_back(mk(1,0,8'h00,8'h00,4'h3,1, 0,4'h1,Z));
    tbl.push_back(mk(1,0,8'h00,8'h00,4'h2,0, 0,4'h0,Z));
    tbl.push_back(mk(1,0,8'h00,8'h00,4'h2,0, 1,4'h0,Z));
    tbl.push_back(mk(1,0,8'hE2,8'h00,4'h2,0, 1,4'h0,8'h81));
    tbl.push_back(mk(1,0,8'h00,8'h00,4'h2,1, 0,4'h2,Z));
    tbl.push_back(mk(1,0,8'h00,8'h00,4'h0,0, 0,4'h0,Z));
    // masked pending source becomes eligible when unmasked; ack in IDLE ignored
    tbl.push_back(mk(0,0,8'h00,8'h00,4'h0,0, 0,4'h0,Z));
    tbl.push_back(mk(1,0,8'h00,8'h00,4'h2,0, 0,4'h0,Z));
    tbl.push_back(mk(1,0,8'hE1,8'h00,4'h2,0, 0,4'h0,8'h02));
    tbl.push_back(mk(1,0,8'h00,8'h00,4'h2,0, 0,4'h0,Z));
    tbl.push_back(mk(1,1,8'hE0,8'h02,4'h2,0, 0,4'h0,Z));
    tbl.push_back(mk(1,0,8'h00,8'h00,4'h2,0, 1,4'h0,Z));
    tbl.push_back(mk(1,0,8'hE2,8'h00,4'h2,0, 1,4'h0,8'h81));
    tbl.push_back(mk(1,0,8'h00,8'h00,4'h2,1, 0,4'h2,Z));
    tbl.push_back(mk(1,0,8'h00,8'h00,4'h0,0, 0,4'h0,Z));
    tbl.push_back(mk(1,0,8'h00,8'h00,4'h0,1, 0,4'h0,Z));
    tbl.push_back(mk(1,0,8'h00,8'h00,4'h0,0, 0,4'h0,Z));

    foreach (tbl[i]) begin
      rst_n = tbl[i].rst_n;
      cyc(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].irq, tbl[i].ack);
      chk($sformatf("v%0d_raise", i), {7'd0, cpu_int_raise}, {7'd0, tbl[i].exp_raise});
      chk($sformatf("v%0d_ack", i), {4'd0, irq_ack_out}, {4'd0, tbl[i].exp_ack});
      chk($sformatf("v%0d_bus", i), bus_data, tbl[i].exp_bus);
    end

    // reset asserted mid-cycle while raising source 2
    rst_n = 1'b1;
    cyc(1, 8'hE0, 8'h0F, 4'h0, 0);
    cyc(0, 8'h00, 8'h00, 4'h4, 0);
    cyc(0, 8'h00, 8'h00, 4'h4, 0);
    chk("rst_pre_raise", {7'd0, cpu_int_raise}, 8'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_raise_drop", {7'd0, cpu_int_raise}, 8'd0);
    chk("rst_ack_now", {4'd0, irq_ack_out}, 8'd0);
    for (int n = 0; n < 2; n++) begin
      cyc(0, 8'h00, 8'h00, 4'h4, 1);
      chk("rst_ack_hold", {4'd0, irq_ack_out}, 8'd0);
      chk("rst_raise_hold", {7'd0, cpu_int_raise}, 8'd0);
    end
    rst_n = 1'b1;
    cyc(0, 8'hE0, 8'h00, 4'h4, 0);
    chk("rst_mask_read", bus_data, 8'h00);
    chk("rst_after_raise", {7'd0, cpu_int_raise}, 8'd0);
    cyc(0, 8'h00, 8'h00, 4'h0, 0);

    // new edge on source 2 in its own ack cycle: set wins, re-raise after ACKED
    rst_n = 1'b0;
    cyc(0, 8'h00, 8'h00, 4'h0, 0);
    rst_n = 1'b1;
    cyc(1, 8'hE0, 8'h0F, 4'h0, 0);
    cyc(0, 8'h00, 8'h00, 4'h4, 0);
    cyc(0, 8'h00, 8'h00, 4'h4, 0);
    chk("re_raise1", {7'd0, cpu_int_raise}, 8'd1);
    cyc(0, 8'h00, 8'h00, 4'h0, 0);
    chk("re_hold_low_irq", {7'd0, cpu_int_raise}, 8'd1);
    cyc(0, 8'h00, 8'h00, 4'h4, 1);
    chk("re_ack1", {4'd0, irq_ack_out}, 8'h04);
    chk("re_raise_drop", {7'd0, cpu_int_raise}, 8'd0);
    cyc(0, 8'hE1, 8'h00, 4'h4, 0);
    chk("re_pending_kept", bus_data, 8'h04);
    chk("re_ack_pulse_end", {4'd0, irq_ack_out}, 8'd0);
    chk("re_guard_low", {7'd0, cpu_int_raise}, 8'd0);
    cyc(0, 8'h00, 8'h00, 4'h4, 0);
    chk("re_raise2", {7'd0, cpu_int_raise}, 8'd1);
    cyc(0, 8'hE2, 8'h00, 4'h4, 0);
    chk("re_cause2", bus_data, 8'h82);
    cyc(0, 8'h00, 8'h00, 4'h4, 1);
    chk("re_ack2", {4'd0, irq_ack_out}, 8'h04);
    cyc(0, 8'h00, 8'h00, 4'h0, 0);
    chk("re_ack2_end", {4'd0, irq_ack_out}, 8'd0);
    cyc(0, 8'hE1, 8'h00, 4'h0, 0);
    chk("re_pending_clr", bus_data, 8'h00);
    cyc(0, 8'h00, 8'h00, 4'h0, 1);
    chk("idle_ack_ack", {4'd0, irq_ack_out}, 8'd0);
    chk("idle_ack_raise", {7'd0, cpu_int_raise}, 8'd0);
    cyc(0, 8'h00, 8'h00, 4'h0, 0);
    chk("idle_ack_after", {4'd0, irq_ack_out}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
